// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter between NREQ byte producers.
// The winning request's byte and parity settings are latched, launched with a one-cycle
// data_valid pulse, and then the transmitter's busy flag is tracked until the frame ends.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   req_valid         per-requester request (held with stable data until req_ready)
//   req_data          byte for requester i at [8i+7:8i]
//   req_par_en/typ    per-requester parity enable / type (0 even, 1 odd)
//   req_ready         one-hot combinational accept strobe
//   tx_p_data         latched byte to transmitter P_DATA
//   tx_data_valid     one-cycle launch pulse to transmitter
//   tx_par_en/typ     latched parity settings to transmitter
//   tx_busy           transmitter busy flag
//   grant_id          index of the requester owning the transmitter
//   tx_done           one-cycle pulse when the frame completes
//   tmo_err           one-cycle pulse when busy never rose after a launch
//
// Optional feature: define UART_TX_SCHED_GAP_EN to insert GAP_CYCLES idle guard cycles after
// every completed frame; tx_done then pulses in the first guard cycle.
module uart_tx_sched #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned BUSY_TMO   = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  input  logic [NREQ-1:0]         req_par_en,
  input  logic [NREQ-1:0]         req_par_typ,
  output logic [NREQ-1:0]         req_ready,
  output logic [7:0]              tx_p_data,
  output logic                    tx_data_valid,
  output logic                    tx_par_en,
  output logic                    tx_par_typ,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    tx_done,
  output logic                    tmo_err
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned TmoW = $clog2(BUSY_TMO + 1);

`ifdef UART_TX_SCHED_GAP_EN
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {StIdle, StLaunch, StWaitBusy, StWaitDone, StGuard} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;
  // GAP_CYCLES only matters when the guard state is built in.
  if (GAP_CYCLES == 0) begin : g_gap_unused
  end
`endif

  state_e            state_q, state_d;
  logic [IdW-1:0]    rr_q, rr_d;
  logic [IdW-1:0]    gid_q, gid_d;
  logic [7:0]        data_q, data_d;
  logic              pe_q, pe_d;
  logic              pt_q, pt_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
`ifdef UART_TX_SCHED_GAP_EN
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
`endif

  // Round-robin pick: first asserted request scanning upward from rr_q, wrapping.
  logic           win_found;
  logic [IdW-1:0] win_idx;
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_q) + k) % NREQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IdW'(idx);
      end
    end
  end

  // Pointer moves just past the requester that last owned the transmitter.
  logic [IdW-1:0] rr_next;
  assign rr_next = (32'(gid_q) == NREQ - 1) ? '0 : gid_q + IdW'(1);

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    gid_d         = gid_q;
    data_d        = data_q;
    pe_d          = pe_q;
    pt_d          = pt_q;
    tmo_cnt_d     = tmo_cnt_q;
`ifdef UART_TX_SCHED_GAP_EN
    gap_cnt_d     = gap_cnt_q;
`endif
    req_ready     = '0;
    tx_data_valid = 1'b0;
    tx_done       = 1'b0;
    tmo_err       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found && !tx_busy) begin
          req_ready[win_idx] = 1'b1;
          data_d             = req_data[32'(win_idx)*8 +: 8];
          pe_d               = req_par_en[win_idx];
          pt_d               = req_par_typ[win_idx];
          gid_d              = win_idx;
          state_d            = StLaunch;
        end
      end
      StLaunch: begin
        tx_data_valid = 1'b1;
        tmo_cnt_d     = '0;
        state_d       = StWaitBusy;
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (32'(tmo_cnt_q) == BUSY_TMO) begin
          // Transmitter never picked the byte up: drop it and move on.
          tmo_err = 1'b1;
          rr_d    = rr_next;
          state_d = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          rr_d = rr_next;
`ifdef UART_TX_SCHED_GAP_EN
          gap_cnt_d = '0;
          state_d   = StGuard;
`else
          tx_done   = 1'b1;
          state_d   = StIdle;
`endif
        end
      end
`ifdef UART_TX_SCHED_GAP_EN
      StGuard: begin
        if (gap_cnt_q == '0) tx_done = 1'b1;
        if (32'(gap_cnt_q) == GAP_CYCLES - 1) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // A reset cycle abandons any frame: no strobes escape while it is applied.
    if (rst) begin
      req_ready     = '0;
      tx_data_valid = 1'b0;
      tx_done       = 1'b0;
      tmo_err       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_q      <= '0;
      gid_q     <= '0;
      data_q    <= '0;
      pe_q      <= 1'b0;
      pt_q      <= 1'b0;
      tmo_cnt_q <= '0;
`ifdef UART_TX_SCHED_GAP_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gid_q     <= gid_d;
      data_q    <= data_d;
      pe_q      <= pe_d;
      pt_q      <= pt_d;
      tmo_cnt_q <= tmo_cnt_d;
`ifdef UART_TX_SCHED_GAP_EN
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign tx_p_data  = data_q;
  assign tx_par_en  = pe_q;
  assign tx_par_typ = pt_q;
  assign grant_id   = gid_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: randomized request rounds plus directed cases, with a
// transmitter model and a scoreboard of expected grants derived from round-robin rules.
module tb_uart_tx_sched;

  localparam int N       = 4;
  localparam int BusyTmo = 4;
  localparam int GapCyc  = 16;
`ifdef UART_TX_SCHED_GAP_EN
  localparam int DoneLag = 1;
  localparam int DoneGap = GapCyc;
`else
  localparam int DoneLag = 0;
  localparam int DoneGap = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_par_en;
  logic [N-1:0]     req_par_typ;
  logic [N-1:0]     req_ready;
  logic [7:0]       tx_p_data;
  logic             tx_data_valid;
  logic             tx_par_en;
  logic             tx_par_typ;
  logic             tx_busy;
  logic [1:0]       grant_id;
  logic             tx_done;
  logic             tmo_err;

  logic busy_m   = 1'b0;
  logic ext_busy = 1'b0;
  assign tx_busy = busy_m | ext_busy;

  uart_tx_sched #(
    .NREQ       (N),
    .BUSY_TMO   (BusyTmo),
    .GAP_CYCLES (GapCyc)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_par_en    (req_par_en),
    .req_par_typ   (req_par_typ),
    .req_ready     (req_ready),
    .tx_p_data     (tx_p_data),
    .tx_data_valid (tx_data_valid),
    .tx_par_en     (tx_par_en),
    .tx_par_typ    (tx_par_typ),
    .tx_busy       (tx_busy),
    .grant_id      (grant_id),
    .tx_done       (tx_done),
    .tmo_err       (tmo_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       pe;
    logic       pt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int   rr_m          = 0;
  int   rnd_start_cyc = 0;
  int   acc_cyc       = 0;
  int   last_end_cyc  = -1;
  bit   last_end_tmo  = 1'b0;
  bit   frame_open    = 1'b0;
  int   force_tmo     = -1;
  int   force_d       = -1;
  int   force_len     = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accept monitor: grant identity, one-hotness and frame-to-accept cadence.
  initial begin
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        check("ready_onehot", $countones(req_ready), 1);
        if (exp_q.size() == 0) check("ready_unexpected", 32'(req_ready), 0);
        else check("ready_id", 32'(req_ready), 32'(1) << exp_q[0].id);
        if (last_end_cyc > rnd_start_cyc)
          check("end_to_accept", cyc - last_end_cyc, last_end_tmo ? 1 : DoneGap);
        acc_cyc = cyc;
      end
    end
  end

  // Transmitter model and launch checker.
  task automatic run_frame(input exp_t e);
    bit tmo;
    int d, len;
    tmo = (force_tmo >= 0) ? (force_tmo != 0) : ($urandom_range(0, 3) == 0);
    d   = (force_d >= 0) ? force_d : int'($urandom_range(0, 3));
    len = (force_len >= 0) ? force_len : int'($urandom_range(1, 10));
    if (tmo) begin
      for (int k = 1; k <= BusyTmo + 1; k++) begin
        @(negedge clk);
        if (rst) return;
        check("tmo_err", 32'(tmo_err), 32'(k == BusyTmo + 1));
        check("no_done_on_tmo", 32'(tx_done), 0);
      end
      last_end_cyc = cyc;
      last_end_tmo = 1'b1;
    end else begin
      repeat (d + 1) @(posedge clk);
      #1 busy_m = 1'b1;
      repeat (len) begin
        @(negedge clk);
        if (rst) begin
          busy_m = 1'b0;
          return;
        end
        check("held_data", 32'(tx_p_data), 32'(e.data));
        check("held_par", 32'({tx_par_en, tx_par_typ}), 32'({e.pe, e.pt}));
        check("busy_quiet", 32'({tx_done, tmo_err}), 0);
      end
      @(posedge clk);
      #1 busy_m = 1'b0;
      for (int k = 0; k <= DoneLag; k++) begin
        @(negedge clk);
        if (rst) return;
        check("tx_done", 32'(tx_done), 32'(k == DoneLag));
      end
      last_end_cyc = cyc;
      last_end_tmo = 1'b0;
      @(negedge clk);
      check("done_one_cycle", 32'(tx_done), 0);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_data_valid) begin
        frame_open = 1'b1;
        if (exp_q.size() == 0) begin
          check("launch_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("accept_to_launch", cyc - acc_cyc, 1);
          check("launch_data", 32'(tx_p_data), 32'(e.data));
          check("launch_par_en", 32'(tx_par_en), 32'(e.pe));
          check("launch_par_typ", 32'(tx_par_typ), 32'(e.pt));
          check("launch_grant", 32'(grant_id), 32'(e.id));
          run_frame(e);
        end
        frame_open = 1'b0;
      end else if (tx_done || tmo_err) begin
        check("stray_end_pulse", 32'({tx_done, tmo_err}), 0);
      end
    end
  end

  // Stimulus helpers.
  task automatic wait_quiet();
    int t;
    for (t = 0; t < 2000; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !frame_open && req_valid == '0) break;
    end
    if (t == 2000) check("quiet_timeout", 32'(exp_q.size()), 0);
  endtask

  // Expected grant order for requests raised together: round-robin from the model pointer.
  task automatic arm(input logic [N-1:0] mask);
    int   last;
    exp_t e;
    last          = rr_m;
    rnd_start_cyc = cyc;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr_m + k) % N;
      if (mask[idx]) begin
        e.id   = idx;
        e.data = req_data[8*idx +: 8];
        e.pe   = req_par_en[idx];
        e.pt   = req_par_typ[idx];
        exp_q.push_back(e);
        last   = idx;
      end
    end
    rr_m      = (last + 1) % N;
    req_valid = mask;
  endtask

  task automatic drain();
    logic [N-1:0] got;
    int t;
    for (t = 0; t < 2000 && req_valid != '0; t++) begin
      @(negedge clk);
      got = req_ready;
      if (got != '0) begin
        @(posedge clk);
        #1 req_valid = req_valid & ~got;
      end
    end
    if (req_valid != '0) check("drain_timeout", 32'(req_valid), 0);
  endtask

  task automatic run_round(input logic [N-1:0] mask);
    wait_quiet();
    arm(mask);
    drain();
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      req_data[8*i +: 8] = 8'($urandom);
      req_par_en[i]      = 1'($urandom_range(0, 1));
      req_par_typ[i]     = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    req_valid   = '0;
    req_data    = '0;
    req_par_en  = '0;
    req_par_typ = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_p_data", 32'(tx_p_data), 0);
    check("rst_valid", 32'(tx_data_valid), 0);
    check("rst_par", 32'({tx_par_en, tx_par_typ}), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_pulses", 32'({tx_done, tmo_err}), 0);

    // Single requester 2, busy one cycle after launch for 11 cycles.
    force_tmo = 0; force_d = 0; force_len = 11;
    req_data[23:16] = 8'hA5; req_par_en[2] = 1'b1; req_par_typ[2] = 1'b0;
    run_round(4'b0100);
    wait_quiet();
    force_d = -1; force_len = -1;

    // All four requesting: two full rotations.
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
    run_round(4'b1111);
    run_round(4'b1111);

    // Busy never rises: timeouts, then the rotation continues past the dropped requesters.
    force_tmo = 1;
    run_round(4'b0110);
    wait_quiet();
    force_tmo = -1;
    fill_random();
    run_round(4'b1111);

    // Transmitter busy from outside: no accept until it drops, then immediately.
    wait_quiet();
    ext_busy = 1'b1;
    arm(4'b0010);
    repeat (6) begin
      @(negedge clk);
      check("ready_while_busy", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1 ext_busy = 1'b0;
    @(negedge clk);
    check("ready_after_busy", 32'(req_ready), 32'(4'b0010));
    @(posedge clk);
    #1 req_valid = '0;

    // Reset in the middle of a long frame; pointer must restart at 0.
    force_tmo = 0; force_d = 0; force_len = 3;
    run_round(4'b0001);
    wait_quiet();
    force_len = 40;
    run_round(4'b0001);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("no_done_in_rst", 32'(tx_done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_p_data", 32'(tx_p_data), 0);
    check("post_rst_par", 32'({tx_par_en, tx_par_typ}), 0);
    check("post_rst_grant", 32'(grant_id), 0);
    check("post_rst_strobes", 32'({tx_data_valid, tx_done, tmo_err}), 0);
    rr_m = 0;
    force_tmo = -1; force_d = -1; force_len = -1;
    fill_random();
    run_round(4'b0011);

    // Random rounds.
    for (int r = 0; r < 40; r++) begin
      wait_quiet();
      fill_random();
      run_round(N'($urandom_range(1, (1 << N) - 1)));
    end
    wait_quiet();
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
